fc_sequencer: RTL

Control sequencer for the fully-connected layer when it is time-multiplexed onto a single shared FP16 multiply-accumulate datapath. It walks every output channel and every input channel and issues synchronous-read addresses for activation, weight and bias memories. It strobes the external MAC accumulator through clear, accumulate and bias-add phases, then hands each finished output channel downstream with a valid/ready handshake. It sits between the layer-level start/done control and the FP16 MAC/adder datapath, replacing the fully parallel per-channel unit array for area-constrained builds.

---
 rtl/fc_sequencer.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/fc_sequencer.sv
// Control sequencer for a fully-connected layer time-multiplexed onto one shared
// MAC datapath: issues act/weight/bias reads and accumulator strobes per output channel.
module fc_sequencer #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned IN_CH      = 84,
  parameter int unsigned OUT_CH     = 10,
  localparam int unsigned IA_W = (IN_CH > 1) ? $clog2(IN_CH) : 1,
  localparam int unsigned OA_W = (OUT_CH > 1) ? $clog2(OUT_CH) : 1,
  localparam int unsigned WA_W = (IN_CH * OUT_CH > 1) ? $clog2(IN_CH * OUT_CH) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic            act_rd_en,
  output logic [IA_W-1:0] act_addr,
  output logic            wgt_rd_en,
  output logic [WA_W-1:0] wgt_addr,
  output logic            bias_rd_en,
  output logic [OA_W-1:0] bias_addr,
  output logic            mac_clr,
  output logic            mac_en,
  output logic            bias_en,
  output logic            out_valid,
  output logic [OA_W-1:0] out_ch,
  input  logic            out_ready
);

  if (IN_CH < 1 || OUT_CH < 1 || DATA_WIDTH < 1) begin : g_bad_params
    $error("fc_sequencer: IN_CH, OUT_CH and DATA_WIDTH must all be at least 1");
  end

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_MAC   = 3'd2;
  localparam logic [2:0] S_BIAS  = 3'd3;
  localparam logic [2:0] S_OUT   = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam logic [IA_W-1:0] K_LAST = IA_W'(IN_CH - 1);
  localparam logic [OA_W-1:0] O_LAST = OA_W'(OUT_CH - 1);

  logic [2:0]      state, state_n;
  logic [OA_W-1:0] o, o_n;
  logic [IA_W-1:0] k, k_n;
  logic [WA_W-1:0] wcnt, wcnt_n;

  logic            busy_n, done_n, act_rd_en_n, wgt_rd_en_n, bias_rd_en_n;
  logic            mac_clr_n, mac_en_n, bias_en_n, out_valid_n;
  logic [IA_W-1:0] act_addr_n;
  logic [WA_W-1:0] wgt_addr_n;
  logic [OA_W-1:0] bias_addr_n, out_ch_n;

  // State, counters and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      o          <= '0;
      k          <= '0;
      wcnt       <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      act_rd_en  <= 1'b0;
      act_addr   <= '0;
      wgt_rd_en  <= 1'b0;
      wgt_addr   <= '0;
      bias_rd_en <= 1'b0;
      bias_addr  <= '0;
      mac_clr    <= 1'b0;
      mac_en     <= 1'b0;
      bias_en    <= 1'b0;
      out_valid  <= 1'b0;
      out_ch     <= '0;
    end else begin
      state      <= state_n;
      o          <= o_n;
      k          <= k_n;
      wcnt       <= wcnt_n;
      busy       <= busy_n;
      done       <= done_n;
      act_rd_en  <= act_rd_en_n;
      act_addr   <= act_addr_n;
      wgt_rd_en  <= wgt_rd_en_n;
      wgt_addr   <= wgt_addr_n;
      bias_rd_en <= bias_rd_en_n;
      bias_addr  <= bias_addr_n;
      mac_clr    <= mac_clr_n;
      mac_en     <= mac_en_n;
      bias_en    <= bias_en_n;
      out_valid  <= out_valid_n;
      out_ch     <= out_ch_n;
    end
  end

  // Next state, then the outputs that state presents, so every output is a flop
  always_comb begin
    state_n      = state;
    o_n          = o;
    k_n          = k;
    wcnt_n       = wcnt;
    busy_n       = 1'b0;
    done_n       = 1'b0;
    act_rd_en_n  = 1'b0;
    act_addr_n   = '0;
    wgt_rd_en_n  = 1'b0;
    wgt_addr_n   = '0;
    bias_rd_en_n = 1'b0;
    bias_addr_n  = '0;
    mac_clr_n    = 1'b0;
    mac_en_n     = 1'b0;
    bias_en_n    = 1'b0;
    out_valid_n  = 1'b0;
    out_ch_n     = '0;

    case (state)
      S_IDLE: begin
        if (start) begin
          state_n = S_CLEAR;
          o_n     = '0;
          k_n     = '0;
          wcnt_n  = '0;
        end
      end
      S_CLEAR: begin
        state_n = S_MAC;
        k_n     = '0;
      end
      S_MAC: begin
        if (k == K_LAST) state_n = S_BIAS;
        else             k_n     = k + IA_W'(1);
      end
      S_BIAS:  state_n = S_OUT;
      S_OUT: begin
        if (out_ready) begin
          if (o == O_LAST) begin
            state_n = S_DONE;
          end else begin
            o_n     = o + OA_W'(1);
            state_n = S_CLEAR;
          end
        end
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase

    busy_n = (state_n != S_IDLE);

    // The weight counter runs continuously across channels; it advances once per read
    case (state_n)
      S_CLEAR: begin
        mac_clr_n   = 1'b1;
        act_rd_en_n = 1'b1;
        wgt_rd_en_n = 1'b1;
        act_addr_n  = '0;
        wgt_addr_n  = wcnt_n;
        wcnt_n      = wcnt_n + WA_W'(1);
      end
      S_MAC: begin
        mac_en_n = 1'b1;
        if (k_n != K_LAST) begin
          act_rd_en_n = 1'b1;
          wgt_rd_en_n = 1'b1;
          act_addr_n  = k_n + IA_W'(1);
          wgt_addr_n  = wcnt_n;
          wcnt_n      = wcnt_n + WA_W'(1);
        end else begin
          bias_rd_en_n = 1'b1;
          bias_addr_n  = o_n;
        end
      end
      S_BIAS:  bias_en_n = 1'b1;
      S_OUT: begin
        out_valid_n = 1'b1;
        out_ch_n    = o_n;
      end
      S_DONE:  done_n = 1'b1;
      default: ;
    endcase
  end

endmodule
